// File: rtl/debug_mem_dumper.sv
// Streams a byte range from the processor debug port, followed by a two's-complement checksum byte.
// One debug address is presented at a time; each byte gets one settle cycle before capture.
module debug_mem_dumper #(
    parameter int unsigned ADDRESS_SIZE = 11,
    parameter int unsigned DATA_SIZE    = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    abort,
    input  logic [ADDRESS_SIZE-1:0] startAddress,
    input  logic [ADDRESS_SIZE-1:0] endAddress,
    output logic [ADDRESS_SIZE-1:0] debugAddress,
    input  logic [DATA_SIZE-1:0]    debugMemOut,
    output logic [DATA_SIZE-1:0]    outData,
    output logic                    outValid,
    input  logic                    outReady,
    output logic                    busy,
    output logic                    done,
    output logic                    rangeError,
    output logic [ADDRESS_SIZE:0]   byteCount
);

    localparam int unsigned COUNT_SIZE = ADDRESS_SIZE + 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        SEND,
        CKSUM,
        DONE
    } state_t;

    state_t                  state;
    logic [ADDRESS_SIZE-1:0] endLatch;
    logic [DATA_SIZE-1:0]    checksum;

    // Dump sequencer; every output is a register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            endLatch     <= '0;
            checksum     <= '0;
            debugAddress <= '0;
            outData      <= '0;
            outValid     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            rangeError   <= 1'b0;
            byteCount    <= '0;
        end else begin
            done       <= 1'b0;
            rangeError <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (endAddress >= startAddress) begin
                            endLatch     <= endAddress;
                            debugAddress <= startAddress;
                            checksum     <= '0;
                            byteCount    <= '0;
                            busy         <= 1'b1;
                            state        <= READ;
                        end else begin
                            rangeError <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (abort) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        outData  <= debugMemOut;
                        checksum <= checksum + debugMemOut;
                        outValid <= 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (abort) begin
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (outReady) begin
                        byteCount <= byteCount + COUNT_SIZE'(1);
                        // Stop at the inclusive end so the top address never wraps.
                        if (debugAddress == endLatch) begin
                            outData <= DATA_SIZE'(0) - checksum;
                            state   <= CKSUM;
                        end else begin
                            debugAddress <= debugAddress + ADDRESS_SIZE'(1);
                            outValid     <= 1'b0;
                            state        <= READ;
                        end
                    end
                end
                CKSUM: begin
                    if (abort) begin
                        outValid <= 1'b0;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (outReady) begin
                        outValid <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_debug_mem_dumper.sv
// Self-checking bench for debug_mem_dumper: table-driven dumps against a range/checksum model,
// plus hand-written abort and asynchronous-reset sequences.
module tb_debug_mem_dumper;

    localparam int unsigned AW = 11;
    localparam int unsigned DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          abort;
    logic [AW-1:0] startAddress;
    logic [AW-1:0] endAddress;
    logic [AW-1:0] debugAddress;
    logic [DW-1:0] debugMemOut;
    logic [DW-1:0] outData;
    logic          outValid;
    logic          outReady;
    logic          busy;
    logic          done;
    logic          rangeError;
    logic [AW:0]   byteCount;

    logic [DW-1:0] mem [2**AW];
    assign debugMemOut = mem[debugAddress];

    always #5 clk = ~clk;

    debug_mem_dumper #(.ADDRESS_SIZE(AW), .DATA_SIZE(DW)) dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .startAddress(startAddress), .endAddress(endAddress),
        .debugAddress(debugAddress), .debugMemOut(debugMemOut),
        .outData(outData), .outValid(outValid), .outReady(outReady),
        .busy(busy), .done(done), .rangeError(rangeError), .byteCount(byteCount)
    );

    int errors = 0;
    int checks = 0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Stream monitor: records accepted bytes, counts done pulses, checks stall stability.
    logic [DW-1:0] captured [$];
    int            doneCount = 0;
    bit            stalled = 1'b0;
    logic [DW-1:0] heldData;

    always @(posedge clk) begin
        if (!reset) begin
            stalled = 1'b0;
        end else begin
            if (stalled && outValid) check("stall_stable", 32'(outData), 32'(heldData));
            if (outValid && outReady) captured.push_back(outData);
            if (done) doneCount++;
            stalled  = outValid && !outReady;
            heldData = outData;
        end
    end

    // Reference: bytes of mem[s..e] in order, then the byte that zeroes the running sum.
    function automatic void expectStream(input int s, input int e, output logic [DW-1:0] q [$]);
        int sum = 0;
        q.delete();
        for (int a = s; a <= e; a++) begin
            q.push_back(mem[a]);
            sum += int'(mem[a]);
        end
        q.push_back(DW'((256 - (sum % 256)) % 256));
    endfunction

    task automatic runDump(input int s, input int e, input bit randReady, input bit expErr);
        logic [DW-1:0] expQ [$];
        int cycles;
        captured.delete();
        doneCount = 0;
        startAddress = AW'(s);
        endAddress   = AW'(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
        if (expErr) begin
            check("range_error_pulse", 32'(rangeError), 1);
            check("range_busy", 32'(busy), 0);
            check("range_valid", 32'(outValid), 0);
            @(negedge clk);
            check("range_error_one_cycle", 32'(rangeError), 0);
            check("range_busy_after", 32'(busy), 0);
            return;
        end
        check("read_busy", 32'(busy), 1);
        check("read_valid_low", 32'(outValid), 0);
        @(negedge clk);
        check("first_valid_latency", 32'(outValid), 1);
        cycles = 2;
        while (busy && cycles < 400) begin
            outReady = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
            if (randReady) begin
                start        = 1'($urandom_range(0, 1));
                startAddress = AW'($urandom);
                endAddress   = AW'($urandom);
            end
            @(negedge clk);
            cycles++;
        end
        start = 1'b0;
        check("dump_timeout", 32'(busy), 0);
        if (!randReady) check("busy_cycles", 32'(cycles - 1), 32'(2 * (e - s + 1) + 2));
        @(negedge clk);
        expectStream(s, e, expQ);
        check("stream_len", 32'(captured.size()), 32'(expQ.size()));
        for (int i = 0; i < expQ.size() && i < captured.size(); i++)
            check($sformatf("stream_byte_%0d", i), 32'(captured[i]), 32'(expQ[i]));
        check("byte_count", 32'(byteCount), 32'(e - s + 1));
        check("done_pulses", 32'(doneCount), 1);
        check("debug_addr_end", 32'(debugAddress), 32'(e));
        check("idle_valid", 32'(outValid), 0);
        check("idle_busy", 32'(busy), 0);
    endtask

    typedef struct {
        int s;
        int e;
        bit randReady;
        bit expErr;
        int expLast;
    } vec_t;

    vec_t vecs [8];
    int   sendSeen;
    int   guard;

    initial begin
        reset = 1'b0; start = 1'b0; abort = 1'b0; outReady = 1'b0;
        startAddress = '0; endAddress = '0;
        for (int i = 0; i < 2**AW; i++) mem[i] = DW'($urandom);
        mem[5] = 8'h10; mem[6] = 8'h20; mem[7] = 8'h30;
        mem[2047] = 8'hFF;

        // Expected checksum bytes below are worked out by hand (-1: random data, model only).
        vecs[0] = '{5, 7, 1'b0, 1'b0, 'hA0};
        vecs[1] = '{9, 4, 1'b0, 1'b1, -1};
        vecs[2] = '{2047, 2047, 1'b0, 1'b0, 'h01};
        vecs[3] = '{0, 15, 1'b1, 1'b0, -1};
        vecs[4] = '{100, 110, 1'b0, 1'b0, -1};
        vecs[5] = '{3, 2, 1'b0, 1'b1, -1};
        vecs[6] = '{2040, 2047, 1'b1, 1'b0, -1};
        vecs[7] = '{0, 0, 1'b0, 1'b0, -1};

        #12;
        check("rst_busy", 32'(busy), 0);
        check("rst_valid", 32'(outValid), 0);
        check("rst_addr", 32'(debugAddress), 0);
        check("rst_data", 32'(outData), 0);
        check("rst_count", 32'(byteCount), 0);
        check("rst_done", 32'(done), 0);
        check("rst_rangeerr", 32'(rangeError), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

        // Abort is ignored in IDLE.
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle_busy", 32'(busy), 0);

        foreach (vecs[i]) begin
            runDump(vecs[i].s, vecs[i].e, vecs[i].randReady, vecs[i].expErr);
            if (vecs[i].expLast >= 0 && captured.size() > 0)
                check($sformatf("vec%0d_cksum_byte", i), 32'(captured[captured.size()-1]), 32'(vecs[i].expLast));
        end

        for (int r = 0; r < 4; r++) begin
            int s = int'($urandom_range(0, 2030));
            runDump(s, s + int'($urandom_range(0, 12)), 1'b1, 1'b0);
        end

        // Abort together with acceptance on the third SEND.
        captured.delete();
        doneCount = 0;
        startAddress = AW'(20); endAddress = AW'(29);
        start = 1'b1; outReady = 1'b1;
        @(negedge clk);
        start = 1'b0;
        sendSeen = 0; guard = 0;
        while (sendSeen < 3 && guard < 50) begin
            @(negedge clk);
            guard++;
            if (outValid) sendSeen++;
        end
        check("abort_reach_send3", 32'(sendSeen), 3);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 32'(busy), 0);
        check("abort_valid", 32'(outValid), 0);
        check("abort_count", 32'(byteCount), 2);
        check("abort_addr_hold", 32'(debugAddress), 22);
        repeat (3) @(negedge clk);
        check("abort_no_done", 32'(doneCount), 0);
        check("abort_count_hold", 32'(byteCount), 2);
        runDump(20, 23, 1'b0, 1'b0);

        // Asynchronous reset between edges during SEND.
        startAddress = AW'(40); endAddress = AW'(45);
        start = 1'b1; outReady = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("rst_mid_in_send", 32'(outValid), 1);
        #2 reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(outValid), 0);
        check("rst_mid_busy", 32'(busy), 0);
        check("rst_mid_count", 32'(byteCount), 0);
        check("rst_mid_addr", 32'(debugAddress), 0);
        start = 1'b1; outReady = 1'b1; abort = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ignores_start", 32'(busy), 0);
        start = 1'b0;
        reset = 1'b1;
        doneCount = 0;
        @(negedge clk);
        check("rst_no_done", 32'(doneCount), 0);
        runDump(0, 0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

endmodule
